// File: rtl/bus_xfer_ctl_if.sv
// -----------------------------------------------------------------------------
// bus_xfer_ctl_if
//
// Purpose:
//   Groups the request/handshake inputs and transceiver control outputs of
//   bus_xfer_ctl into one bundle.
//
// Signals:
//   req    transfer request (sampled only while the controller is idle)
//   rd     direction captured with req: 1 = receive from bus, 0 = transmit
//   src    transmit operand select captured with req: 0 = A, 1 = B
//   gnt    bus grant from the arbiter (transmit only)
//   rdack  consumer acknowledge of received data (receive only)
//   busy   high from accept until completion
//   done   one-clock completion pulse
//   drcp   transceiver data-register clock strobe, active high
//   sel    transceiver operand select, 0 = A, 1 = B
//   be_    transceiver bus-driver enable, active low
//   rle_   transceiver receive-latch enable, active low (low = transparent)
//   oe_    transceiver receive-output enable, active low
//
// Modports:
//   slave  : the controller side (takes requests, drives transceiver controls)
//   master : the requester / environment side
// -----------------------------------------------------------------------------
interface bus_xfer_ctl_if;
  logic req;
  logic rd;
  logic src;
  logic gnt;
  logic rdack;
  logic busy;
  logic done;
  logic drcp;
  logic sel;
  logic be_;
  logic rle_;
  logic oe_;

  modport slave (
    input  req, rd, src, gnt, rdack,
    output busy, done, drcp, sel, be_, rle_, oe_
  );

  modport master (
    output req, rd, src, gnt, rdack,
    input  busy, done, drcp, sel, be_, rle_, oe_
  );
endinterface

// File: rtl/bus_xfer_ctl.sv
// -----------------------------------------------------------------------------
// bus_xfer_ctl
//
// Purpose:
//   Sequences a bidirectional bus transceiver for one transfer at a time.
//   Transmit: strobe the operand into the data register, wait for the bus
//   grant, then drive the bus for SETTLE + HOLD consecutive granted clocks.
//   Losing the grant part-way restarts the whole drive window on regrant.
//   Receive: open the receive latch for SETTLE clocks, close it, then present
//   the latched data until the consumer acknowledges it.
//
// Parameters:
//   SETTLE  bus settle time in clocks, 1..15
//   HOLD    post-settle drive hold in clocks, 0..15 (0 skips the hold phase)
//
// Ports:
//   clk   single clock, all state changes on its rising edge
//   rst   asynchronous active-high reset
//   bus   bus_xfer_ctl_if.slave: req/rd/src/gnt/rdack in,
//         busy/done/drcp/sel/be_/rle_/oe_ out
//
// Every output comes straight from a flop, so no input reaches an output
// within the same clock. Output values are computed together with the next
// state, which makes them take effect on the edge that enters a state.
// -----------------------------------------------------------------------------
module bus_xfer_ctl #(
  parameter int SETTLE = 2,
  parameter int HOLD   = 1
) (
  input  logic           clk,
  input  logic           rst,
  bus_xfer_ctl_if.slave  bus
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);
  localparam logic [3:0] HOLD_C   = 4'(HOLD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAITG,
    S_DRIVE,
    S_HOLD,
    S_OPEN,
    S_OUT
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q,   cnt_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;
  logic       drcp_q,  drcp_d;
  logic       sel_q,   sel_d;
  logic       be_n_q,  be_n_d;
  logic       rle_n_q, rle_n_d;
  logic       oe_n_q,  oe_n_d;

  // The counter holds the clocks remaining in the current phase, including
  // the clock that is in progress; a value of 1 (or less, defensively) marks
  // the last clock of the phase so it never wraps below zero.
  logic last_clk;
  assign last_clk = (cnt_q <= 4'd1);

  always_comb begin
    // Outputs default to their inactive levels; each state re-asserts what
    // it needs for the coming clock. busy and sel are sticky.
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    drcp_d  = 1'b0;
    sel_d   = sel_q;
    be_n_d  = 1'b1;
    rle_n_d = 1'b1;
    oe_n_d  = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        // The idle clock after a completion is what keeps back-to-back
        // requests at least one clock apart; req is only looked at here.
        if (bus.req) begin
          busy_d = 1'b1;
          if (bus.rd) begin
            // Receive leaves sel untouched.
            state_d = S_OPEN;
            rle_n_d = 1'b0;
            cnt_d   = SETTLE_C;
          end else begin
            state_d = S_LOAD;
            drcp_d  = 1'b1;
            sel_d   = bus.src;
          end
        end
      end

      S_LOAD: begin
        // The strobe lasted exactly one clock; the driver stays off here so
        // drcp and an enabled driver never overlap.
        state_d = S_WAITG;
      end

      S_WAITG: begin
        if (bus.gnt) begin
          state_d = S_DRIVE;
          be_n_d  = 1'b0;
          cnt_d   = SETTLE_C;
        end
      end

      S_DRIVE: begin
        if (!bus.gnt) begin
          // Grant lost: release the bus and start over from the grant wait.
          state_d = S_WAITG;
          cnt_d   = 4'd0;
        end else if (last_clk) begin
          if (HOLD_C == 4'd0) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_HOLD;
            be_n_d  = 1'b0;
            cnt_d   = HOLD_C;
          end
        end else begin
          be_n_d = 1'b0;
          cnt_d  = cnt_q - 4'd1;
        end
      end

      S_HOLD: begin
        if (!bus.gnt) begin
          state_d = S_WAITG;
          cnt_d   = 4'd0;
        end else if (last_clk) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          be_n_d = 1'b0;
          cnt_d  = cnt_q - 4'd1;
        end
      end

      S_OPEN: begin
        if (last_clk) begin
          // Close the latch and present its contents in the same edge.
          state_d = S_OUT;
          oe_n_d  = 1'b0;
          cnt_d   = 4'd0;
        end else begin
          rle_n_d = 1'b0;
          cnt_d   = cnt_q - 4'd1;
        end
      end

      S_OUT: begin
        if (bus.rdack) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          oe_n_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drcp_q  <= 1'b0;
      sel_q   <= 1'b0;
      be_n_q  <= 1'b1;
      rle_n_q <= 1'b1;
      oe_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drcp_q  <= drcp_d;
      sel_q   <= sel_d;
      be_n_q  <= be_n_d;
      rle_n_q <= rle_n_d;
      oe_n_q  <= oe_n_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.drcp = drcp_q;
  assign bus.sel  = sel_q;
  assign bus.be_  = be_n_q;
  assign bus.rle_ = rle_n_q;
  assign bus.oe_  = oe_n_q;

endmodule

// File: tb/tb_bus_xfer_ctl.sv
// -----------------------------------------------------------------------------
// tb_bus_xfer_ctl
//
// Drives bus_xfer_ctl (SETTLE=2, HOLD=1) with directed scenarios followed by
// random traffic. Expected outputs come from a transaction-level model: a
// phase plus a single "granted clocks so far" count for transmit and an
// "open clocks so far" count for receive. Inputs change on the falling edge,
// outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_bus_xfer_ctl;

  localparam int SETTLE = 2;
  localparam int HOLD   = 1;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_WAIT = 2;
  localparam int P_DRV  = 3;
  localparam int P_OPEN = 4;
  localparam int P_OUT  = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  bus_xfer_ctl_if bus ();

  bus_xfer_ctl #(.SETTLE(SETTLE), .HOLD(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int   m_phase;
  int   m_run;
  int   m_open;
  logic m_sel;
  logic m_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;
  int n_xfer  = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_run   = 0;
    m_open  = 0;
    m_sel   = 1'b0;
    m_done  = 1'b0;
  endtask

  // One rising edge of the reference behaviour, using the inputs as driven.
  task automatic model_step();
    m_done = 1'b0;
    case (m_phase)
      P_IDLE: if (bus.req) begin
        if (bus.rd) begin
          m_phase = P_OPEN;
          m_open  = 1;
        end else begin
          m_phase = P_LOAD;
          m_sel   = bus.src;
        end
      end
      P_LOAD: m_phase = P_WAIT;
      P_WAIT: if (bus.gnt) begin
        m_phase = P_DRV;
        m_run   = 1;
      end
      P_DRV: begin
        if (!bus.gnt) m_phase = P_WAIT;
        else if (m_run == SETTLE + HOLD) begin
          m_phase = P_IDLE;
          m_done  = 1'b1;
        end else m_run++;
      end
      P_OPEN: begin
        if (m_open == SETTLE) m_phase = P_OUT;
        else m_open++;
      end
      P_OUT: if (bus.rdack) begin
        m_phase = P_IDLE;
        m_done  = 1'b1;
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic check_all();
    chk("busy", bus.busy, m_phase != P_IDLE);
    chk("done", bus.done, m_done);
    chk("drcp", bus.drcp, m_phase == P_LOAD);
    chk("sel",  bus.sel,  m_sel);
    chk("be_",  bus.be_,  m_phase != P_DRV);
    chk("rle_", bus.rle_, m_phase != P_OPEN);
    chk("oe_",  bus.oe_,  m_phase != P_OUT);
    chk("be_rle_excl",  bus.be_ | bus.rle_, 1'b1);
    chk("drcp_be_excl", ~(bus.drcp & ~bus.be_), 1'b1);
    if (bus.done === 1'b1) begin
      n_xfer++;
      $display("[TB] xfer %0d complete at cycle %0d sel=%b", n_xfer, cycle, bus.sel);
    end
  endtask

  // Called just after a falling edge: apply inputs, take one rising edge,
  // then compare on the next falling edge.
  task automatic cycle_step(input logic req, input logic rd, input logic src,
                            input logic gnt, input logic rdack);
    bus.req   = req;
    bus.rd    = rd;
    bus.src   = src;
    bus.gnt   = gnt;
    bus.rdack = rdack;
    @(posedge clk);
    model_step();
    cycle++;
    @(negedge clk);
    check_all();
  endtask

  // Mid-cycle reset: outputs must go inactive before any clock edge.
  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    cycle++;
    check_all();
  endtask

  initial begin
    logic [5:0] ex_be;
    logic [5:0] ex_done;
    logic [5:0] ex_drcp;
    logic [5:0] ex_busy;

    bus.req = 1'b0; bus.rd = 1'b0; bus.src = 1'b0; bus.gnt = 1'b0; bus.rdack = 1'b0;
    model_reset();

    // Reset asserted before the first edge: outputs forced asynchronously.
    #1 rst = 1'b1;
    #2 check_all();
    @(negedge clk);
    rst = 1'b0;
    check_all();

    // Transmit, src=B, grant always present: fixed trace for edges 1..6.
    ex_be   = 6'b100011;
    ex_done = 6'b100000;
    ex_drcp = 6'b000001;
    ex_busy = 6'b011111;
    for (int i = 0; i < 6; i++) begin
      cycle_step(i == 0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("ex_be",   bus.be_,  ex_be[i]);
      chk("ex_done", bus.done, ex_done[i]);
      chk("ex_drcp", bus.drcp, ex_drcp[i]);
      chk("ex_busy", bus.busy, ex_busy[i]);
    end
    cycle_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Transmit, src=A, grant withheld until the sixth edge.
    for (int i = 1; i <= 11; i++)
      cycle_step(i == 1, 1'b0, 1'b0, i >= 6, 1'b0);

    // Receive, acknowledge on the sixth edge; sel keeps its last value.
    for (int i = 1; i <= 8; i++)
      cycle_step(i == 1, 1'b1, 1'b1, 1'b0, i == 6);

    // Grant dropped at the second drive clock, then regranted.
    for (int i = 1; i <= 12; i++)
      cycle_step(i == 1, 1'b0, 1'b1, i != 5, 1'b0);

    // Grant dropped during the hold clock.
    for (int i = 1; i <= 12; i++)
      cycle_step(i == 1, 1'b0, 1'b0, i != 6, 1'b0);

    // Reset during OUT, then a normal transmit.
    for (int i = 1; i <= 5; i++)
      cycle_step(i == 1, 1'b1, 1'b0, 1'b1, 1'b0);
    async_reset_pulse();
    for (int i = 1; i <= 8; i++)
      cycle_step(i == 1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset during DRIVE, then a normal receive.
    for (int i = 1; i <= 4; i++)
      cycle_step(i == 1, 1'b0, 1'b1, 1'b1, 1'b0);
    async_reset_pulse();
    for (int i = 1; i <= 6; i++)
      cycle_step(i == 1, 1'b1, 1'b0, 1'b0, i == 5);

    // req held high with immediate grant/ack: back-to-back transfers.
    for (int i = 0; i < 40; i++)
      cycle_step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1);

    // Random traffic with occasional mid-cycle resets.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset_pulse();
      else cycle_step(1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      $urandom_range(0, 7) != 0,
                      $urandom_range(0, 9) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
